// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag and FSM state types shared by alu_seq and its multiplier
package alu_pkg;
    typedef enum logic [4:0] {
        OP_LD  = 5'h01, OP_ADD = 5'h03, OP_SUB = 5'h04, OP_AND = 5'h05,
        OP_OR  = 5'h06, OP_XOR = 5'h07, OP_NOT = 5'h08, OP_SL  = 5'h09,
        OP_SR  = 5'h0A, OP_ADC = 5'h0B, OP_SBC = 5'h0C, OP_ASR = 5'h0D,
        OP_MUL = 5'h0E
    } alu_op_e;
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;
    typedef enum logic {IDLE, BUSY} alu_state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product
// o_done/o_prod are valid combinationally during the last busy cycle so the caller registers at start+WIDTH
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod
);
    localparam int CNT_W = $clog2(WIDTH);
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
    assign o_done = r_busy & (r_cnt == CNT_W'(WIDTH - 1));
    assign o_prod = w_acc_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_busy <= ~o_done;
            r_cnt  <= r_cnt + 1'b1;
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_acc  <= w_acc_nxt;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake and NZCV flags
// `ALU_MUL_EN adds the iterative MUL (opcode 0E) and its IDLE/BUSY FSM; otherwise 0E is undefined
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       instruction,
    input  logic [WIDTH-1:0] bus_A,
    input  logic [WIDTH-1:0] bus_B,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_bus,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);
    localparam int SHAMT_W = $clog2(WIDTH);
    logic [WIDTH-1:0]   r_bus;
    alu_flags_t         r_flags;
    logic               r_valid;
    alu_op_e            w_op;
    logic               w_accept, w_mul_start, w_mul_done;
    logic [WIDTH-1:0]   w_prod, w_bop, w_res;
    logic [SHAMT_W-1:0] w_sh;
    logic               w_sh0, w_cin, w_add_v, w_def, w_c, w_v;
    logic [WIDTH:0]     w_sum, w_shl, w_shr, w_asr;
    assign w_op     = alu_op_e'(instruction);
    assign w_accept = in_valid & in_ready;
    assign w_sh     = bus_B[SHAMT_W-1:0];
    assign w_sh0    = (w_sh == '0);
    // one adder serves ADD/SUB/ADC/SBC: subtraction is A + ~B + carry-in
    assign w_bop    = (w_op == OP_SUB || w_op == OP_SBC) ? ~bus_B : bus_B;
    assign w_cin    = (w_op == OP_SUB) | ((w_op == OP_ADC || w_op == OP_SBC) & r_flags.c);
    assign w_sum    = {1'b0, bus_A} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
    assign w_add_v  = (bus_A[WIDTH-1] == w_bop[WIDTH-1]) & (w_sum[WIDTH-1] != bus_A[WIDTH-1]);
    // shifts carry one extra bit so the last bit shifted out lands at a fixed position
    assign w_shl    = {1'b0, bus_A} << w_sh;
    assign w_shr    = {bus_A, 1'b0} >> w_sh;
    assign w_asr    = $signed({bus_A, 1'b0}) >>> w_sh;
    always_comb begin
        w_def = 1'b1;
        w_res = '0;
        w_c   = r_flags.c;
        w_v   = 1'b0;
        case (w_op)
            OP_LD:  w_res = bus_A;
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_add_v;
            end
            OP_AND: w_res = bus_A & bus_B;
            OP_OR:  w_res = bus_A | bus_B;
            OP_XOR: w_res = bus_A ^ bus_B;
            OP_NOT: w_res = ~bus_A;
            OP_SL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_sh0 ? r_flags.c : w_shl[WIDTH];
            end
            OP_SR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_sh0 ? r_flags.c : w_shr[0];
            end
            OP_ASR: begin
                w_res = w_asr[WIDTH:1];
                w_c   = w_sh0 ? r_flags.c : w_asr[0];
            end
            default: w_def = 1'b0;
        endcase
    end
`ifdef ALU_MUL_EN
    alu_state_e r_state;
    assign in_ready    = ~reset & (r_state == IDLE);
    assign w_mul_start = w_accept & (w_op == OP_MUL);
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_mul_start),
        .i_a     (bus_A),
        .i_b     (bus_B),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );
    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_mul_start ? BUSY : w_mul_done ? IDLE : r_state;
    end
`else
    assign in_ready    = ~reset;
    assign w_mul_start = 1'b0;
    assign w_mul_done  = 1'b0;
    assign w_prod      = '0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus   <= '0;
            r_flags <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_mul_done | (w_accept & ~w_mul_start);
            if (w_mul_done) begin
                r_bus   <= w_prod;
                r_flags <= '{z: w_prod == '0, n: w_prod[WIDTH-1], c: 1'b0, v: 1'b0};
            end else if (w_accept & ~w_mul_start) begin
                r_bus <= w_res;
                if (w_def) r_flags <= '{z: w_res == '0, n: w_res[WIDTH-1], c: w_c, v: w_v};
            end
        end
    end
    assign out_valid = r_valid;
    assign out_bus   = r_bus;
    assign Z         = r_flags.z;
    assign N         = r_flags.n;
    assign C         = r_flags.c;
    assign V         = r_flags.v;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq against a behavioural reference model
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [4:0]    instruction = '0;
    logic [W-1:0]  bus_A = '0, bus_B = '0;
    logic          in_ready, out_valid, Z, N, C, V;
    logic [W-1:0]  out_bus;
    logic          v8 = 1'b0;
    logic [4:0]    op8 = '0;
    logic [7:0]    a8 = '0, b8 = '0;
    logic          rdy8, ov8, z8, n8, c8, vv8;
    logic [7:0]    bus8;
    int            checks = 0, errors = 0;
    logic [W-1:0]  m_bus;
    logic          m_valid, m_z, m_n, m_c, m_v;
    int            m_busy = 0;
    logic [W-1:0]  m_pa, m_pb;
    logic [4:0]    ops [16] = '{5'h01, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                                5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h00, 5'h1F, 5'h0B};

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .bus_A(bus_A), .bus_B(bus_B),
        .out_valid(out_valid), .out_bus(out_bus), .Z(Z), .N(N), .C(C), .V(V)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
        .instruction(op8), .bus_A(a8), .bus_B(b8),
        .out_valid(ov8), .out_bus(bus8), .Z(z8), .N(n8), .C(c8), .V(vv8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ovf(input longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    // reference semantics from plain integer arithmetic on 64-bit values
    function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, output logic def, output logic [31:0] res,
                                    output logic c, output logic v);
        longint ua, ub, sa, sb, t, nb;
        int sh;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        nb = cin ? 64'sd0 : 64'sd1;
        sh = int'(b[4:0]);
        def = 1'b1; res = '0; c = cin; v = 1'b0;
        case (op)
            5'h01: res = a;
            5'h03: begin t = ua + ub; res = t[31:0]; c = t > 64'hFFFFFFFF; v = ovf(sa + sb); end
            5'h04: begin res = a - b; c = ua >= ub; v = ovf(sa - sb); end
            5'h05: res = a & b;
            5'h06: res = a | b;
            5'h07: res = a ^ b;
            5'h08: res = ~a;
            5'h09: begin res = a << sh; if (sh != 0) c = a[32 - sh]; end
            5'h0A: begin res = a >> sh; if (sh != 0) c = a[sh - 1]; end
            5'h0B: begin t = ua + ub + (cin ? 64'sd1 : 64'sd0); res = t[31:0]; c = t > 64'hFFFFFFFF;
                         v = ovf(sa + sb + (cin ? 64'sd1 : 64'sd0)); end
            5'h0C: begin t = ua - ub - nb; res = t[31:0]; c = t >= 0; v = ovf(sa - sb - nb); end
            5'h0D: begin res = $signed(a) >>> sh; if (sh != 0) c = a[sh - 1]; end
            default: def = 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic d, c, v;
        logic [31:0] r;
        logic [63:0] p;
        if (reset) begin
            m_bus <= '0; m_valid <= 1'b0; m_busy <= 0;
            m_z <= 1'b0; m_n <= 1'b0; m_c <= 1'b0; m_v <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    p = {32'b0, m_pa} * {32'b0, m_pb};
                    m_bus <= p[31:0]; m_valid <= 1'b1;
                    m_z <= (p[31:0] == 0); m_n <= p[31]; m_c <= 1'b0; m_v <= 1'b0;
                end
            end else if (in_valid) begin
                if (MUL_EN && instruction == 5'h0E) begin
                    m_busy <= W; m_pa <= bus_A; m_pb <= bus_B;
                end else begin
                    ref_alu(instruction, bus_A, bus_B, m_c, d, r, c, v);
                    m_valid <= 1'b1;
                    m_bus <= r;
                    if (d) begin m_z <= (r == 0); m_n <= r[31]; m_c <= c; m_v <= v; end
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        chk("in_ready", 32'(in_ready), 32'(!reset && m_busy == 0));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_bus", out_bus, m_bus);
        chk("flags_ZNCV", 32'({Z, N, C, V}), 32'({m_z, m_n, m_c, m_v}));
    end

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1; instruction = op; bus_A = a; bus_B = b;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] bus, input logic [3:0] flags);
        chk({name, "_bus"}, out_bus, bus);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_flags"}, 32'({Z, N, C, V}), 32'(flags));
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_bus", out_bus, 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", 32'({Z, N, C, V}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        send(5'h01, 32'd12345, 32'd0);          lit("ld", 32'd12345, 4'b0000);
        @(posedge clk); #2;
        chk("ld_pulse_end", 32'(out_valid), 32'd0);
        send(5'h03, 32'hFFFFFFFF, 32'd1);       lit("add_wrap", 32'h0, 4'b1010);
        send(5'h0B, 32'd5, 32'd6);              lit("adc", 32'd12, 4'b0000);
        send(5'h04, 32'h80000000, 32'd1);       lit("sub_ovf", 32'h7FFFFFFF, 4'b0011);
        send(5'h04, 32'h10000, 32'h10000);      lit("sub_zero", 32'h0, 4'b1010);
        send(5'h09, 32'hAAAAAAAA, 32'd1);       lit("sl", 32'h55555554, 4'b0010);
        send(5'h0A, 32'h1234, 32'd0);           lit("sr_zero", 32'h1234, 4'b0010);
        send(5'h0D, 32'h80000000, 32'd4);       lit("asr", 32'hF8000000, 4'b0100);
        send(5'h1F, 32'h1234, 32'd5);           lit("undef", 32'h0, 4'b0100);
        send(5'h0C, 32'd5, 32'd5);              lit("sbc_borrow", 32'hFFFFFFFF, 4'b0100);

`ifdef ALU_MUL_EN
        @(negedge clk);
        in_valid = 1'b1; instruction = 5'h0E; bus_A = 32'd1234; bus_B = 32'd5678;
        @(posedge clk); #2;
        instruction = 5'h01; bus_A = 32'hDEAD;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #2;
            if (i < W) begin
                chk("mul_busy_ready", 32'(in_ready), 32'd0);
                chk("mul_busy_valid", 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        lit("mul", 32'd7006652, 4'b0000);
        chk("mul_ready_after", 32'(in_ready), 32'd1);
`else
        send(5'h0E, 32'd1234, 32'd5678);        lit("mul_undef", 32'h0, 4'b0100);
`endif

        send(5'h0E, 32'd3, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_bus", out_bus, 32'd0);
        chk("midrst_flags", 32'({Z, N, C, V}), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ready_after", 32'(in_ready), 32'd1);
        repeat (W + 4) @(posedge clk);

        @(negedge clk);
        v8 = 1'b1; op8 = 5'h03; a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk); #2;
        chk("w8_add_bus", 32'(bus8), 32'h80);
        chk("w8_add_flags", 32'({z8, n8, c8, vv8}), 32'b0101);
        @(negedge clk);
        op8 = 5'h0A; a8 = 8'h81; b8 = 8'h01;
        @(posedge clk); #2;
        v8 = 1'b0;
        chk("w8_sr_bus", 32'(bus8), 32'h40);
        chk("w8_sr_flags", 32'({z8, n8, c8, vv8}), 32'b0010);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            instruction = ops[$urandom_range(0, 15)];
            bus_A = rnd();
            bus_B = rnd();
            reset = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        repeat (W + 4) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
